// File: rtl/demodulation_bit_decide.sv
// demodulation_bit_decide: latches ten Q16.16 segment metrics, sums them serially
// over ten cycles and issues a hard bit, saturated soft metric and erasure flag.
module demodulation_bit_decide #(
    parameter logic [31:0] ERASE_THR = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] segment_0,
    input  logic [31:0] segment_1,
    input  logic [31:0] segment_2,
    input  logic [31:0] segment_3,
    input  logic [31:0] segment_4,
    input  logic [31:0] segment_5,
    input  logic [31:0] segment_6,
    input  logic [31:0] segment_7,
    input  logic [31:0] segment_8,
    input  logic [31:0] segment_9,
    output logic        bit_out,
    output logic [31:0] metric,
    output logic        erase,
    output logic        valid,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
    state_t             state_q, state_d;
    logic [31:0]        seg_in [10];
    logic [31:0]        seg_q  [10];
    logic [3:0]         cnt_q, cnt_d;
    logic signed [35:0] acc_q, acc_d;
    logic [35:0]        acc_abs;
    logic               load, ovf;
    logic               bit_q, bit_d, erase_q, erase_d, valid_q, valid_d, busy_q, busy_d;
    logic [31:0]        metric_q, metric_d;

    assign seg_in = '{segment_0, segment_1, segment_2, segment_3, segment_4,
                      segment_5, segment_6, segment_7, segment_8, segment_9};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE  ? (start ? ACCUM : IDLE) :
                  state_q == ACCUM ? (cnt_q == 4'd9 ? OUT : ACCUM) : IDLE;
    end

    // 36-bit accumulator: ten 32-bit signed terms can never wrap
    assign load    = state_q == IDLE && start;
    assign acc_abs = acc_q[35] ? -acc_q : acc_q;
    assign ovf     = acc_q[35:31] != {5{acc_q[35]}};

    always_comb begin
        cnt_d    = load ? 4'd0 : state_q == ACCUM ? cnt_q + 4'd1 : cnt_q;
        acc_d    = load ? 36'sd0 :
                   state_q == ACCUM ? acc_q + {{4{seg_q[cnt_q][31]}}, seg_q[cnt_q]} : acc_q;
        valid_d  = state_q == OUT;
        busy_d   = state_d != IDLE;
        bit_d    = state_q == OUT ? !acc_q[35] : bit_q;
        metric_d = state_q != OUT ? metric_q :
                   ovf ? (acc_q[35] ? 32'h8000_0000 : 32'h7FFF_FFFF) : acc_q[31:0];
        erase_d  = state_q == OUT ? acc_abs < {4'd0, ERASE_THR} : erase_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            bit_q    <= 1'b0;
            metric_q <= '0;
            erase_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < 10; i++) seg_q[i] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            bit_q    <= bit_d;
            metric_q <= metric_d;
            erase_q  <= erase_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            for (int i = 0; i < 10; i++) if (load) seg_q[i] <= seg_in[i];
        end
    end

    always_comb begin
        bit_out = bit_q;
        metric  = metric_q;
        erase   = erase_q;
        valid   = valid_q;
        busy    = busy_q;
    end
endmodule

// File: tb/tb_demodulation_bit_decide.sv
// tb_demodulation_bit_decide: directed vector table plus handshake, capture and
// mid-frame reset sequences.
module tb_demodulation_bit_decide;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] seg [10];
    logic        bit_out, erase, valid, busy;
    logic [31:0] metric;
    int          total = 0, bad = 0;

    localparam logic [31:0] P1 = 32'h0001_0000;
    localparam logic [31:0] N1 = 32'hFFFF_0000;

    typedef struct {
        logic [31:0] seg [10];
        logic        b;
        logic [31:0] m;
        logic        e;
    } vec_t;

    always #5 clk = ~clk;

    demodulation_bit_decide dut (
        .clk(clk), .reset(reset), .start(start),
        .segment_0(seg[0]), .segment_1(seg[1]), .segment_2(seg[2]), .segment_3(seg[3]),
        .segment_4(seg[4]), .segment_5(seg[5]), .segment_6(seg[6]), .segment_7(seg[7]),
        .segment_8(seg[8]), .segment_9(seg[9]),
        .bit_out(bit_out), .metric(metric), .erase(erase), .valid(valid), .busy(busy)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < 10; i++) seg[i] = v;
    endtask

    function automatic vec_t mk(input logic [31:0] a, input int na, input logic [31:0] o,
                                input logic b, input logic [31:0] m, input logic e);
        vec_t v;
        for (int i = 0; i < 10; i++) v.seg[i] = i < na ? a : o;
        v.b = b; v.m = m; v.e = e;
        return v;
    endfunction

    // One frame: capture, scramble inputs, poke start during OUT, check results
    task automatic run_frame(input string nm, input vec_t v);
        int cyc, busy_n;
        @(negedge clk);
        seg = v.seg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_all(32'h5A5A_5A5A);
        cyc = 1;
        busy_n = 0;
        while (cyc < 30) begin
            if (busy) busy_n++;
            if (valid) break;
            if (cyc == 11) start = 1'b1;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({nm, " latency"}, 64'(cyc), 64'd12);
        check({nm, " busy_cycles"}, 64'(busy_n), 64'd11);
        check({nm, " bit"}, 64'(bit_out), 64'(v.b));
        check({nm, " metric"}, 64'(metric), 64'(v.m));
        check({nm, " erase"}, 64'(erase), 64'(v.e));
        @(negedge clk);
        check({nm, " valid_drop"}, 64'(valid), 64'd0);
        check({nm, " start_in_out_ignored"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t vecs [13];
        int   cyc;
        vecs[0]  = mk(P1, 10, 0, 1'b1, 32'h000A_0000, 1'b0);
        vecs[1]  = mk(N1, 10, 0, 1'b0, 32'hFFF6_0000, 1'b0);
        vecs[2]  = mk(32'h0000_4000, 1, 0, 1'b1, 32'h0000_4000, 1'b1);
        vecs[3]  = mk(32'h7FFF_FFFF, 10, 0, 1'b1, 32'h7FFF_FFFF, 1'b0);
        vecs[4]  = mk(32'h8000_0000, 10, 0, 1'b0, 32'h8000_0000, 1'b0);
        vecs[5]  = mk(32'h7FFF_FFFF, 5, 32'h8000_0001, 1'b1, 32'h0000_0000, 1'b1);
        vecs[6]  = mk(32'h0000_8000, 1, 0, 1'b1, 32'h0000_8000, 1'b0);
        vecs[7]  = mk(32'h0000_7FFF, 1, 0, 1'b1, 32'h0000_7FFF, 1'b1);
        vecs[8]  = mk(32'hFFFF_8000, 1, 0, 1'b0, 32'hFFFF_8000, 1'b0);
        vecs[9]  = mk(32'hFFFF_8001, 1, 0, 1'b0, 32'hFFFF_8001, 1'b1);
        vecs[10] = mk(0, 10, 0, 1'b1, 32'h0000_0000, 1'b1);
        vecs[11] = mk(32'h8000_0000, 1, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0);
        vecs[12] = mk(32'h7FFF_FFFF, 1, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0);

        reset = 1'b0;
        start = 1'b0;
        set_all(P1);
        repeat (3) @(negedge clk);
        check("reset bit", 64'(bit_out), 64'd0);
        check("reset metric", 64'(metric), 64'd0);
        check("reset erase", 64'(erase), 64'd0);
        check("reset valid", 64'(valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back frames with start held high, alternating +1.0 / -1.0
        @(negedge clk);
        set_all(P1);
        start = 1'b1;
        @(negedge clk);
        set_all(N1);
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (!valid && cyc < 30) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("b2b%0d spacing", k), 64'(cyc), 64'd11);
            check($sformatf("b2b%0d bit", k), 64'(bit_out), 64'(k % 2 == 0));
            check($sformatf("b2b%0d metric", k), 64'(metric),
                  64'(k % 2 == 0 ? 32'h000A_0000 : 32'hFFF6_0000));
            @(negedge clk);
            check($sformatf("b2b%0d busy_after_accept", k), 64'(busy), 64'd1);
            set_all(k % 2 == 0 ? P1 : N1);
        end
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("b2b drained", 64'(busy), 64'd0);

        // Reset asserted right after E5 of a frame
        set_all(32'h0003_0000);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst bit", 64'(bit_out), 64'd0);
        check("midrst metric", 64'(metric), 64'd0);
        check("midrst erase", 64'(erase), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst valid", 64'(valid), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (valid) cyc++;
        end
        check("midrst no_valid", 64'(cyc), 64'd0);
        run_frame("postrst", vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
